// File: rtl/counter_enable_gen_pkg.sv
// Shared definitions for the counter enable generator and its neighbours.
// Holds the control-FSM state encoding, default timing constants and the
// next-state rule so every user of the counter agrees on them.
package counter_pkg;

  // Control FSM encoding; 2'd3 is unused and recovers to ST_STOP.
  typedef enum logic [1:0] {
    ST_STOP = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2
  } state_t;

  // Defaults sized for a 50 MHz board clock: 1 Hz run rate, 10 ms debounce.
  localparam int DEF_DIV       = 50_000_000;
  localparam int DEF_DB_CYCLES = 500_000;

  // Next-state rule for the run/stop/step controller. A run press beats a
  // step press when both arrive together in STOP.
  function automatic state_t next_state(input state_t cur,
                                        input logic   run_press,
                                        input logic   step_press);
    state_t nxt;
    nxt = ST_STOP;
    case (cur)
      ST_STOP: begin
        if (run_press) begin
          nxt = ST_RUN;
        end else if (step_press) begin
          nxt = ST_STEP;
        end else begin
          nxt = ST_STOP;
        end
      end
      ST_RUN:  nxt = run_press ? ST_STOP : ST_RUN;
      ST_STEP: nxt = ST_STOP;
      default: nxt = ST_STOP;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/counter_enable_gen_debouncer.sv
// Button conditioner: 2-flop synchroniser, stability-count debouncer and
// rising-edge press pulse. Press appears DB_CYCLES+1 edges after the raw
// change is first sampled; releases produce no pulse.
module button_debouncer
  import counter_pkg::*;
#(
  parameter int DB_CYCLES = DEF_DB_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  localparam int              CW       = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync_1;
  logic          sync_2;
  logic [CW-1:0] cnt;
  logic          level_d;

  // Two-flop synchroniser; only sync_2 is allowed into the debouncer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
    end else begin
      sync_1 <= btn_raw;
      sync_2 <= sync_1;
    end
  end

  // Count consecutive cycles of disagreement; accept the new level once it
  // has held for DB_CYCLES cycles, restart the count on any agreement.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (sync_2 == level) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      level <= sync_2;
      cnt   <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // One-cycle delayed copy of the debounced level for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level_d <= 1'b0;
    end else begin
      level_d <= level;
    end
  end

  assign press = level & ~level_d;

endmodule

// File: rtl/counter_enable_gen.sv
// Enable generator for the 4-bit counter: debounced run/stop and step
// buttons drive a STOP/RUN/STEP controller and a DIV-cycle prescaler.
// enable is a registered single-cycle pulse; running mirrors the RUN state.
module counter_enable_gen
  import counter_pkg::*;
#(
  parameter int DIV       = DEF_DIV,
  parameter int DB_CYCLES = DEF_DB_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_run,
  input  logic btn_step,
  output logic enable,
  output logic running
);

  localparam int            PW     = $clog2(DIV);
  localparam logic [PW-1:0] P_LAST = PW'(DIV - 1);

  logic          run_level;
  logic          run_pulse;
  logic          step_level;
  logic          step_pulse;
  logic          run_press;
  logic          step_press;
  state_t        state;
  state_t        state_nxt;
  logic [PW-1:0] p;

  button_debouncer #(
    .DB_CYCLES(DB_CYCLES)
  ) u_run_btn (
    .clk    (clk),
    .reset  (reset),
    .btn_raw(btn_run),
    .level  (run_level),
    .press  (run_pulse)
  );

  button_debouncer #(
    .DB_CYCLES(DB_CYCLES)
  ) u_step_btn (
    .clk    (clk),
    .reset  (reset),
    .btn_raw(btn_step),
    .level  (step_level),
    .press  (step_pulse)
  );

  // A press is only trusted while its debounced level is actually high.
  assign run_press  = run_pulse & run_level;
  assign step_press = step_pulse & step_level;

  assign state_nxt = next_state(state, run_press, step_press);

  // Controller, prescaler and registered outputs. The prescaler only runs
  // while staying in RUN, so every entry into RUN starts the period from 0
  // and the stop edge clears it. enable looks at the current state and
  // prescaler, so a stop on the last prescaler count still emits its pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_STOP;
      p       <= '0;
      enable  <= 1'b0;
      running <= 1'b0;
    end else begin
      state   <= state_nxt;
      running <= (state_nxt == ST_RUN);
      enable  <= ((state == ST_RUN) && (p == P_LAST)) || (state == ST_STEP);
      if ((state == ST_RUN) && (state_nxt == ST_RUN)) begin
        p <= (p == P_LAST) ? '0 : p + 1'b1;
      end else begin
        p <= '0;
      end
    end
  end

endmodule

// File: tb/tb_counter_enable_gen.sv
// Bench for counter_enable_gen with DIV=4, DB_CYCLES=3: directed scenarios
// with hand-computed timing plus randomized button traffic, all checked
// against a sample-history model of the buttons and the controller rules.
module tb_counter_enable_gen;

  localparam int DIV = 4;
  localparam int DB  = 3;

  logic clk      = 1'b0;
  logic reset    = 1'b1;
  logic btn_run  = 1'b0;
  logic btn_step = 1'b0;
  logic enable;
  logic running;

  always #5 clk = ~clk;

  counter_enable_gen #(
    .DIV      (DIV),
    .DB_CYCLES(DB)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .btn_run (btn_run),
    .btn_step(btn_step),
    .enable  (enable),
    .running (running)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Button: the debounced level flips at edge t when the raw samples taken
  // at edges t-2 .. t-1-DB all differ from the current level.
  localparam int M_STOP = 0, M_RUN = 1, M_STEP = 2;
  int ms     = M_STOP;
  int ecount = 0;
  int entry  = 0;
  bit m_en   = 1'b0;
  bit m_run  = 1'b0;
  bit rh_r[DB+2];
  bit rh_s[DB+2];
  bit lv_r = 1'b0, lvp_r = 1'b0, lv_s = 1'b0, lvp_s = 1'b0;

  function automatic bit flips(input bit h[DB+2], input bit lv);
    for (int i = 2; i <= DB + 1; i++) begin
      if (h[i] == lv) return 1'b0;
    end
    return 1'b1;
  endfunction

  always @(posedge clk or negedge reset) begin : model
    bit pr, ps, en_n;
    if (!reset) begin
      for (int i = 0; i < DB + 2; i++) begin
        rh_r[i] = 1'b0;
        rh_s[i] = 1'b0;
      end
      lv_r = 1'b0; lvp_r = 1'b0; lv_s = 1'b0; lvp_s = 1'b0;
      ms = M_STOP; m_en = 1'b0; m_run = 1'b0;
    end else begin
      ecount++;
      pr = lv_r && !lvp_r;
      ps = lv_s && !lvp_s;
      // pulse every DIV edges counted from the edge that entered RUN
      en_n = ((ms == M_RUN) && ((ecount - entry) % DIV == 0)) || (ms == M_STEP);
      case (ms)
        M_STOP: begin
          if (pr) begin ms = M_RUN; entry = ecount; end
          else if (ps) ms = M_STEP;
        end
        M_RUN:   if (pr) ms = M_STOP;
        default: ms = M_STOP;
      endcase
      m_en  = en_n;
      m_run = (ms == M_RUN);
      for (int i = DB + 1; i > 0; i--) begin
        rh_r[i] = rh_r[i-1];
        rh_s[i] = rh_s[i-1];
      end
      rh_r[0] = btn_run;
      rh_s[0] = btn_step;
      lvp_r = lv_r;
      lvp_s = lv_s;
      if (flips(rh_r, lv_r)) lv_r = !lv_r;
      if (flips(rh_s, lv_s)) lv_s = !lv_s;
    end
  end

  // ---------------- per-cycle comparison ----------------
  bit         cmp_on  = 1'b0;
  logic [3:0] cnt_dut = 4'd0;  // downstream 4-bit counter driven by DUT enable

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("enable_vs_model", int'(enable), int'(m_en));
      chk("running_vs_model", int'(running), int'(m_run));
      if (enable) cnt_dut = cnt_dut + 4'd1;
    end
  end

  // ---------------- stimulus helpers ----------------
  bit en_h[1:30], run_h[1:30], men_h[1:30], mrun_h[1:30];

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  // Drive the buttons, hold them for 'hold' cycles and record n cycles.
  task automatic press_and_watch(input bit r, input bit s, input int hold, input int n);
    btn_run  = r;
    btn_step = s;
    for (int j = 1; j <= n; j++) begin
      tick(1);
      en_h[j]   = enable;
      run_h[j]  = running;
      men_h[j]  = m_en;
      mrun_h[j] = m_run;
      if (j == hold) begin
        btn_run  = 1'b0;
        btn_step = 1'b0;
      end
    end
  endtask

  function automatic int en_sum(input int lo, input int hi);
    int s = 0;
    for (int j = lo; j <= hi; j++) s += int'(en_h[j]);
    return s;
  endfunction

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int c0, c1, guard, rises, hr, hs;
    bit seen, found;
    bit prev_run;
    bit pat[8];

    // reset state
    #1 reset = 1'b0;
    tick(2);
    chk("reset_enable", int'(enable), 0);
    chk("reset_running", int'(running), 0);
    reset = 1'b1;
    cmp_on = 1'b1;

    // idle 50 cycles
    seen = 1'b0;
    for (int j = 0; j < 50; j++) begin
      tick(1);
      if (enable || running) seen = 1'b1;
    end
    chk("idle_quiet", int'(seen), 0);

    // run from STOP: running after k+5, pulses after k+9, k+13, k+17
    cnt_dut = 4'd0;
    press_and_watch(1'b1, 1'b0, 10, 18);
    chk("run_k4_running", int'(run_h[5]), 0);
    chk("run_k5_running", int'(run_h[6]), 1);
    chk("run_k8_enable", int'(en_h[9]), 0);
    chk("run_k9_enable", int'(en_h[10]), 1);
    chk("run_k10_enable", int'(en_h[11]), 0);
    chk("run_k13_enable", int'(en_h[14]), 1);
    chk("run_k17_enable", int'(en_h[18]), 1);
    chk("run_counter_3", int'(cnt_dut), 3);
    chk("model_pin_run_k5", int'(mrun_h[6]), 1);
    chk("model_pin_en_k8", int'(men_h[9]), 0);
    chk("model_pin_en_k9", int'(men_h[10]), 1);
    tick(8);

    // stop while running
    press_and_watch(1'b1, 1'b0, 6, 8);
    chk("stop_k4_running", int'(run_h[5]), 1);
    chk("stop_k5_running", int'(run_h[6]), 0);
    chk("stop_tail_le1", int'(en_sum(7, 8) <= 1), 1);
    chk("stop_tail_k7", int'(en_h[8]), 0);
    c1 = int'(cnt_dut);
    tick(40);
    chk("stop_counter_hold", int'(cnt_dut), c1);

    // single step
    c0 = int'(cnt_dut);
    press_and_watch(1'b0, 1'b1, 6, 14);
    chk("step_pulse_k6", int'(en_h[7]), 1);
    chk("step_one_pulse", en_sum(1, 14), 1);
    chk("step_counter_inc", int'(cnt_dut), (c0 + 1) % 16);

    // step up to 15, then one more wraps to 0
    guard = 0;
    while (cnt_dut != 4'd15 && guard < 20) begin
      press_and_watch(1'b0, 1'b1, 6, 14);
      guard++;
    end
    chk("step_reach_15", int'(cnt_dut), 15);
    press_and_watch(1'b0, 1'b1, 6, 14);
    chk("step_wrap_0", int'(cnt_dut), 0);

    // bounce shorter than DB_CYCLES: no press
    pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    seen = 1'b0;
    for (int j = 0; j < 8; j++) begin
      btn_run = pat[j];
      tick(1);
      if (enable || running) seen = 1'b1;
    end
    btn_run = 1'b0;
    for (int j = 0; j < 15; j++) begin
      tick(1);
      if (enable || running) seen = 1'b1;
    end
    chk("bounce_no_press", int'(seen), 0);

    // same bounce then held high: exactly one transition to RUN
    rises = 0;
    prev_run = running;
    for (int j = 0; j < 8; j++) begin
      btn_run = pat[j];
      tick(1);
      if (running && !prev_run) rises++;
      prev_run = running;
    end
    btn_run = 1'b1;
    for (int j = 0; j < 14; j++) begin
      tick(1);
      if (running && !prev_run) rises++;
      prev_run = running;
    end
    chk("bounce_then_hold_rises", rises, 1);
    chk("bounce_then_hold_running", int'(running), 1);
    btn_run = 1'b0;
    tick(8);

    // asynchronous reset while enable is high
    found = 1'b0;
    for (int j = 0; j < 12; j++) begin
      if (!found) begin
        tick(1);
        if (enable) found = 1'b1;
      end
    end
    chk("reset_found_pulse", int'(found), 1);
    #2 reset = 1'b0;
    #1;
    chk("async_reset_enable", int'(enable), 0);
    chk("async_reset_running", int'(running), 0);
    tick(3);
    reset = 1'b1;
    tick(10);
    chk("after_reset_stopped", int'(running), 0);
    press_and_watch(1'b1, 1'b0, 8, 12);
    chk("restart_k4_running", int'(run_h[5]), 0);
    chk("restart_k5_running", int'(run_h[6]), 1);
    chk("restart_k8_enable", int'(en_h[9]), 0);
    chk("restart_k9_enable", int'(en_h[10]), 1);
    tick(8);
    press_and_watch(1'b1, 1'b0, 6, 8);
    tick(10);

    // run and step together from STOP: run wins, no step pulse
    press_and_watch(1'b1, 1'b1, 8, 12);
    chk("both_no_step_pulse", en_sum(1, 9), 0);
    chk("both_k5_running", int'(run_h[6]), 1);
    chk("both_k9_enable", int'(en_h[10]), 1);
    tick(8);
    press_and_watch(1'b1, 1'b0, 6, 8);
    tick(10);

    // randomized button traffic with occasional resets
    hr = 0;
    hs = 0;
    repeat (3000) begin
      if (hr == 0) begin
        btn_run = 1'($urandom_range(0, 1));
        hr = $urandom_range(1, 10);
      end else hr--;
      if (hs == 0) begin
        btn_step = 1'($urandom_range(0, 1));
        hs = $urandom_range(1, 10);
      end else hs--;
      if ($urandom_range(0, 299) == 0) begin
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
      end
      tick(1);
    end
    btn_run = 1'b0;
    btn_step = 1'b0;
    tick(5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/counter_enable_gen.md
Name: counter_enable_gen

Overview:
- Upstream stage for the 4-bit D-flip-flop counter. Drives the counter's `enable` input.
- Turns two raw push-buttons (run/stop toggle, single-step) plus a programmable clock prescaler into clean, single-cycle `enable` pulses.
- Lets the counter free-run at `clk`/DIV, or be stepped one count at a time while stopped.
- Contains synchronisers, debouncers, a prescaler and a 3-state control FSM.

Parameters:
- DIV, 50000000, prescaler period in `clk` cycles between `enable` pulses in RUN; legal range ≥ 2.
- DB_CYCLES, 500000, consecutive stable cycles a synchronised button must hold before its debounced level changes; legal range ≥ 1.

Ports:
- clk  input  1  single system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset. Low clears all state immediately, independent of `clk`.
- btn_run  input  1  raw asynchronous run/stop button, active-high.
- btn_step  input  1  raw asynchronous step button, active-high.
- enable  output  1  registered one-cycle pulse; connects to the counter `enable` input.
- running  output  1  high while the FSM is in RUN.

Behaviour:
- Reset (`reset` = 0), asynchronous:
  - All synchroniser, debounce, prescaler and edge-detect flops clear to 0.
  - FSM goes to STOP.
  - `enable` = 0 and `running` = 0 immediately, without waiting for a clock edge.
  - Asserting reset mid-operation, including mid-pulse, aborts everything.
  - After release, the first button press is honoured normally.
- Synchronisers: each button passes through a 2-flop synchroniser; the debouncer sees only the second flop.
- Debouncer, per button:
  - Counter increments each cycle the synchronised input differs from the debounced level.
  - Counter clears to 0 on any cycle where they are equal.
  - On the edge where the counter would reach DB_CYCLES, the debounced level takes the new value and the counter clears.
  - Press pulse = debounced level AND NOT its one-cycle-delayed copy; high for exactly one cycle per debounced rising edge.
  - Releases produce no pulse.
  - Latency: an input change first sampled at edge k changes the FSM state at edge k+DB_CYCLES+2.
- FSM states STOP, RUN, STEP:
  - STOP: run_press → RUN. step_press → STEP. Both in the same cycle → RUN (run wins).
  - RUN: run_press → STOP. step_press ignored.
  - STEP: unconditionally → STOP after one cycle. Both presses ignored.
- Prescaler p:
  - Width ceil(log2(DIV)).
  - Held at 0 in STOP and STEP.
  - In RUN, increments each cycle and wraps DIV-1 → 0.
  - Cleared on the RUN → STOP transition.
  - Restarting always begins from 0.
- enable, registered:
  - Next value = (state==RUN && p==DIV-1) || (state==STEP).
  - First pulse in RUN is asserted exactly DIV edges after the edge that entered RUN. Thereafter exactly one pulse every DIV cycles; never two consecutive high cycles when DIV ≥ 2.
  - Stop coinciding with p==DIV-1: the final pulse is still emitted on the next edge, then no more.
  - STEP: exactly one pulse, asserted on the edge that leaves STEP.
- running: registered decode of state==RUN; no extra latency relative to the state register.
- A button held indefinitely produces exactly one press pulse.
- Bounce shorter than DB_CYCLES produces no press.

Decomposition:
- Shared package (counter_pkg):
  - 2-bit state encoding constants ST_STOP=0, ST_RUN=1, ST_STEP=2. Encoding 3 is illegal and recovers to ST_STOP.
  - Default DIV and DB_CYCLES constants, so the counter top level and benches share them.
- Sub-module: button_debouncer, parameter DB_CYCLES.
  - Contains the 2-flop synchroniser, stability counter and rising-edge pulse.
  - Ports clk, reset, btn_raw, level, press.
  - Instantiated twice.
- Prescaler and FSM live in the top module.

Test Plan (bench overrides DIV=4, DB_CYCLES=3):
- Reset then idle, no presses for 50 cycles → enable=0 and running=0 throughout.
- btn_run held high from edge k → running=1 after edge k+5; enable pulses after edges k+9, k+13, k+17, each one cycle wide; downstream counter counts 0→1→2→3.
- Running; press btn_run again (held ≥ 6 cycles) → running=0 after the FSM edge; at most one further pulse (only if coincident with p=3); counter holds value for 40 cycles.
- Stopped; btn_step pulse held 6 cycles → exactly one enable pulse, counter +1. Stopped at 15; step once → counter wraps to 0.
- Bounce btn_run as 1,0,1,0 with 2-cycle stable runs, then low → no press, running stays 0. Same pattern then held high → single transition to RUN.
- Running with enable high; drive reset=0 between clock edges → enable and running drop to 0 before the next edge. Release → STOP; a new btn_run press restarts with first pulse DIV edges after entering RUN.
- Simultaneous btn_run and btn_step rising in STOP → RUN entered, no step pulse.
